// File: rtl/crypto_core_unit.sv
// crypto_core_unit: iterative add/rotate/xor block cipher responder.
// Operand, key and mode are latched by Load_data. start_execute_crypto runs
// ROUNDS rounds, one per clock, and fin_crypto reports completion. Store_data
// copies the internal result to data_out so the memory write path can pick it up.
module crypto_core_unit #(
    parameter int DATA_W = 16,
    parameter int ROUNDS = 8,
    parameter int ROT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Load_data,
    input  logic              start_crypt,
    input  logic              start_decrypt,
    input  logic              start_execute_crypto,
    input  logic              Store_data,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              fin_crypto,
    output logic              busy,
    output logic [DATA_W-1:0] data_out
);

    // Round index width: ROUNDS is at most 255, so eight bits always suffice.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [DATA_W-1:0]  data_q,     data_d;
    logic [DATA_W-1:0]  key_q,      key_d;
    logic [CNT_W-1:0]   idx_q,      idx_d;
    logic               dec_q,      dec_d;
    logic               busy_q,     busy_d;
    logic               fin_q,      fin_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;

    logic [DATA_W-1:0]  round_key;
    logic [DATA_W-1:0]  enc_next;
    logic [DATA_W-1:0]  dec_next;
    logic               last_round;

    // Rotate left by amt (0..DATA_W-1): the upper half of the doubled word
    // shifted left is exactly the rotated value.
    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                               input int amt);
        logic [2*DATA_W-1:0] t;
        t = {x, x} << amt;
        return t[2*DATA_W-1:DATA_W];
    endfunction

    // Rotate right by amt (0..DATA_W-1): lower half of the doubled word shifted right.
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                               input int amt);
        logic [2*DATA_W-1:0] t;
        t = {x, x} >> amt;
        return t[DATA_W-1:0];
    endfunction

    // Round key: the key rotated left by the round index modulo the word width.
    function automatic logic [DATA_W-1:0] rk_of(input logic [DATA_W-1:0] key,
                                                input logic [CNT_W-1:0]  idx);
        int amt;
        amt = int'({{(32-CNT_W){1'b0}}, idx}) % DATA_W;
        return rotl(key, amt);
    endfunction

    // Forward round: modular add, fixed rotate, xor with the same round key.
    function automatic logic [DATA_W-1:0] enc_round(input logic [DATA_W-1:0] d,
                                                    input logic [DATA_W-1:0] rk);
        logic [DATA_W-1:0] s;
        s = d + rk;
        return rotl(s, ROT) ^ rk;
    endfunction

    // Inverse round: undo the xor, undo the rotate, undo the modular add.
    function automatic logic [DATA_W-1:0] dec_round(input logic [DATA_W-1:0] d,
                                                    input logic [DATA_W-1:0] rk);
        logic [DATA_W-1:0] r;
        r = rotr(d ^ rk, ROT);
        return r - rk;
    endfunction

    // Round datapath: both directions are evaluated, the mode picks one.
    always_comb begin
        round_key  = rk_of(key_q, idx_q);
        enc_next   = enc_round(data_q, round_key);
        dec_next   = dec_round(data_q, round_key);
        // Decrypt walks the round keys backwards, so it ends at index 0.
        last_round = dec_q ? (idx_q == '0) : (idx_q == LAST_IDX);
    end

    // Next-state and next-output logic for the control sequence.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        key_d      = key_q;
        idx_d      = idx_q;
        dec_d      = dec_q;
        busy_d     = busy_q;
        fin_d      = fin_q;
        data_out_d = data_out_q;

        case (state_q)
            RUN: begin
                // Every control input is ignored here so a round cannot be corrupted.
                data_d = dec_q ? dec_next : enc_next;
                if (last_round) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                end else begin
                    idx_d = dec_q ? (idx_q - CNT_W'(1)) : (idx_q + CNT_W'(1));
                end
            end
            default: begin
                if (Load_data) begin
                    // A load always wins over an execute arriving on the same edge.
                    data_d  = data_in;
                    key_d   = key_in;
                    dec_d   = start_decrypt & ~start_crypt;
                    state_d = LOADED;
                    fin_d   = 1'b0;
                end else if ((state_q == LOADED) && start_execute_crypto) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    fin_d   = 1'b0;
                    idx_d   = dec_q ? LAST_IDX : '0;
                end
                if (Store_data) begin
                    data_out_d = data_q;
                end
            end
        endcase
    end

    // State, datapath and output registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            key_q      <= '0;
            idx_q      <= '0;
            dec_q      <= 1'b0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            key_q      <= key_d;
            idx_q      <= idx_d;
            dec_q      <= dec_d;
            busy_q     <= busy_d;
            fin_q      <= fin_d;
            data_out_q <= data_out_d;
        end
    end

    assign fin_crypto = fin_q;
    assign busy       = busy_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_crypto_core_unit.sv
// Directed bench for crypto_core_unit: a default instance (8 rounds) and a
// single-round instance share the stimulus; expected values are hand-computed.
module tb_crypto_core_unit;

    localparam int DW     = 16;
    localparam int NROUND = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_data;
    logic          start_crypt;
    logic          start_decrypt;
    logic          start_exec;
    logic          store_data;
    logic [DW-1:0] data_in;
    logic [DW-1:0] key_in;

    logic          fin0, busy0;
    logic [DW-1:0] dout0;
    logic          fin1, busy1;
    logic [DW-1:0] dout1;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] cipher;

    always #5 clk = ~clk;

    crypto_core_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .Load_data            (load_data),
        .start_crypt          (start_crypt),
        .start_decrypt        (start_decrypt),
        .start_execute_crypto (start_exec),
        .Store_data           (store_data),
        .data_in              (data_in),
        .key_in               (key_in),
        .fin_crypto           (fin0),
        .busy                 (busy0),
        .data_out             (dout0)
    );

    crypto_core_unit #(.ROUNDS(1)) dut1 (
        .clk                  (clk),
        .rst                  (rst),
        .Load_data            (load_data),
        .start_crypt          (start_crypt),
        .start_decrypt        (start_decrypt),
        .start_execute_crypto (start_exec),
        .Store_data           (store_data),
        .data_in              (data_in),
        .key_in               (key_in),
        .fin_crypto           (fin1),
        .busy                 (busy1),
        .data_out             (dout1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] d, input logic [DW-1:0] k,
                        input logic enc, input logic dec);
        load_data     = 1'b1;
        data_in       = d;
        key_in        = k;
        start_crypt   = enc;
        start_decrypt = dec;
        tick();
        load_data     = 1'b0;
        start_crypt   = 1'b0;
        start_decrypt = 1'b0;
    endtask

    task automatic exec();
        start_exec = 1'b1;
        tick();
        start_exec = 1'b0;
    endtask

    task automatic store();
        store_data = 1'b1;
        tick();
        store_data = 1'b0;
    endtask

    // Wait (bounded) for the default instance to finish.
    task automatic wait_fin0(input string tag);
        int t;
        t = 0;
        while (!fin0 && t < 40) begin
            tick();
            t++;
        end
        chk({tag, "_fin"}, 32'(fin0), 32'd1);
    endtask

    // Execute on the default instance and measure busy length and fin latency,
    // counting edges after the execute-sampling edge.
    task automatic go(input string tag);
        int n;
        int t;
        n = 0;
        t = 0;
        exec();
        while (!fin0 && t < 40) begin
            if (busy0) n++;
            tick();
            t++;
        end
        chk({tag, "_fin"},       32'(fin0),  32'd1);
        chk({tag, "_busy_cyc"},  32'(n),     32'(NROUND));
        chk({tag, "_fin_edge"},  32'(t),     32'(NROUND));
        chk({tag, "_busy_end"},  32'(busy0), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        load_data     = 1'b0;
        start_crypt   = 1'b0;
        start_decrypt = 1'b0;
        start_exec    = 1'b0;
        store_data    = 1'b0;
        data_in       = '0;
        key_in        = '0;

        // Reset values, during and after reset
        tick();
        tick();
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_fin",   32'(fin0),  32'd0);
        chk("rst_dout",  32'(dout0), 32'd0);
        chk("rst_dout1", 32'(dout1), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy0), 32'd0);
        chk("post_rst_fin",  32'(fin0),  32'd0);
        chk("post_rst_dout", 32'(dout0), 32'd0);

        // Execute in IDLE is ignored
        exec();
        chk("idle_exec_busy", 32'(busy0), 32'd0);
        tick();
        chk("idle_exec_busy2", 32'(busy0), 32'd0);
        chk("idle_exec_fin",   32'(fin0),  32'd0);

        // Zero key: eight rotl-3 rounds net rotl 8
        load(16'h1234, 16'h0000, 1'b1, 1'b0);
        go("enc_k0");
        chk("enc_k0_dout_pre", 32'(dout0), 32'd0);
        store();
        chk("enc_k0_dout", 32'(dout0), 32'h3412);
        tick();
        chk("dout_hold", 32'(dout0), 32'h3412);

        // Execute in DONE leaves fin set
        exec();
        chk("done_exec_fin",  32'(fin0),  32'd1);
        chk("done_exec_busy", 32'(busy0), 32'd0);

        // Single-round instance: latency and value
        load(16'h0001, 16'h0000, 1'b1, 1'b0);
        chk("r1_load_clears_fin", 32'(fin0), 32'd0);
        exec();
        chk("r1_busy",  32'(busy1), 32'd1);
        chk("r1_fin0",  32'(fin1),  32'd0);
        tick();
        chk("r1_fin",   32'(fin1),  32'd1);
        chk("r1_idle",  32'(busy1), 32'd0);
        store();
        chk("r1_dout", 32'(dout1), 32'h0008);
        wait_fin0("r1_drain");

        // Single round with key 1: rotl(2,3)^1 = 0x11, and its inverse
        load(16'h0001, 16'h0001, 1'b1, 1'b0);
        exec();
        for (int k = 0; k < 10; k++) tick();
        store();
        chk("r1_enc_k1", 32'(dout1), 32'h0011);
        load(16'h0011, 16'h0001, 1'b0, 1'b1);
        exec();
        for (int k = 0; k < 10; k++) tick();
        store();
        chk("r1_dec_k1", 32'(dout1), 32'h0001);

        // Eight rounds, key 1, data 0 (round keys 1,2,4..0x80) -> 0xFFFF
        load(16'h0000, 16'h0001, 1'b1, 1'b0);
        go("enc_k1");
        store();
        chk("enc_k1_dout", 32'(dout0), 32'hFFFF);
        load(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        go("dec_k1");
        store();
        chk("dec_k1_dout", 32'(dout0), 32'h0000);

        // Round trip with a dense key
        load(16'hBEEF, 16'hA5C3, 1'b1, 1'b0);
        go("rt_enc");
        store();
        cipher = dout0;
        chk("rt_cipher_differs", 32'(cipher == 16'hBEEF), 32'd0);
        load(cipher, 16'hA5C3, 1'b0, 1'b1);
        go("rt_dec");
        store();
        chk("rt_plain", 32'(dout0), 32'hBEEF);

        // Load and Store during RUN are ignored
        load(16'h1234, 16'h0000, 1'b1, 1'b0);
        exec();
        tick();
        tick();
        load(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        store();
        chk("run_store_ignored", 32'(dout0), 32'hBEEF);
        chk("run_still_busy",    32'(busy0), 32'd1);
        wait_fin0("run_load");
        store();
        chk("run_load_ignored", 32'(dout0), 32'h3412);

        // Load and execute on the same edge: load wins, no run starts
        load_data   = 1'b1;
        start_exec  = 1'b1;
        start_crypt = 1'b1;
        data_in     = 16'h0000;
        key_in      = 16'h0001;
        tick();
        load_data   = 1'b0;
        start_exec  = 1'b0;
        start_crypt = 1'b0;
        chk("both_busy", 32'(busy0), 32'd0);
        chk("both_fin",  32'(fin0),  32'd0);
        tick();
        chk("both_busy2", 32'(busy0), 32'd0);
        go("both_run");
        store();
        chk("both_dout", 32'(dout0), 32'hFFFF);

        // start_crypt and start_decrypt together select encrypt
        load(16'h0000, 16'h0001, 1'b1, 1'b1);
        go("mode_pri");
        store();
        chk("mode_pri_dout", 32'(dout0), 32'hFFFF);

        // Reset mid-RUN, then a clean operation
        load(16'h1234, 16'h0000, 1'b1, 1'b0);
        exec();
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_fin",  32'(fin0),  32'd0);
        chk("midrst_dout", 32'(dout0), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("after_rst_busy", 32'(busy0), 32'd0);
        load(16'h1234, 16'h0000, 1'b1, 1'b0);
        go("after_rst");
        store();
        chk("after_rst_dout", 32'(dout0), 32'h3412);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
